// File: rtl/vending_core_param.sv
// Vending controller: coin credit with overflow rejection, per-product price/stock, timed dispense,
// greedy change over valid/ready. Define VEND_TIMEOUT_EN to auto-cancel an idle COLLECT phase.
module vending_core_param #(
  parameter int                            NUM_PRODUCTS    = 4,
  parameter int                            BAL_W           = 8,
  parameter logic [NUM_PRODUCTS*BAL_W-1:0] PRICES          = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                            MAX_BALANCE     = 99,
  parameter int                            STOCK_W         = 4,
  parameter int                            INIT_STOCK      = 5,
  parameter int                            DISPENSE_CYCLES = 10,
  parameter int                            TIMEOUT_CYCLES  = 1000,
  localparam int                           SEL_W           = $clog2(NUM_PRODUCTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coin_valid,
  input  logic [1:0]              coin_value,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel_id,
  input  logic                    cancel,
  input  logic                    restock,
  input  logic                    change_ready,
  output logic [BAL_W-1:0]        balance,
  output logic [1:0]              state,
  output logic                    vend_valid,
  output logic [SEL_W-1:0]        vend_id,
  output logic                    change_valid,
  output logic [1:0]              change_coin,
  output logic                    coin_reject,
  output logic                    err_funds,
  output logic                    err_sold_out,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_VEND = 2'd2, S_CHANGE = 2'd3} state_e;

  localparam int                 DCNT_W       = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0]  DCNT_LAST    = DCNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [BAL_W:0]     MAX_BAL      = (BAL_W + 1)'(MAX_BALANCE);
  localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(INIT_STOCK);
`ifdef VEND_TIMEOUT_EN
  localparam int                 TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  function automatic logic [BAL_W-1:0] coin_amount(input logic [1:0] code);
    case (code)
      2'd0:    coin_amount = BAL_W'(1);
      2'd1:    coin_amount = BAL_W'(2);
      2'd2:    coin_amount = BAL_W'(5);
      default: coin_amount = BAL_W'(10);
    endcase
  endfunction

  function automatic logic [1:0] greedy_code(input logic [BAL_W-1:0] bal);
    if (bal >= BAL_W'(10))     greedy_code = 2'd3;
    else if (bal >= BAL_W'(5)) greedy_code = 2'd2;
    else if (bal >= BAL_W'(2)) greedy_code = 2'd1;
    else                       greedy_code = 2'd0;
  endfunction

  state_e             state_q, state_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];
  logic [SEL_W-1:0]   vend_id_q, vend_id_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               vend_valid_q, vend_valid_d;
  logic               change_valid_q, change_valid_d;
  logic [1:0]         change_coin_q, change_coin_d;
  logic               coin_reject_q, coin_reject_d;
  logic               err_funds_q, err_funds_d;
  logic               err_sold_out_q, err_sold_out_d;
`ifdef VEND_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

  logic               sel_hit;
  logic [BAL_W-1:0]   sel_price;
  logic [STOCK_W-1:0] sel_stock;
  logic [BAL_W:0]     coin_sum;
  logic               coin_ok;

  // Match against each real product so out-of-range sel_id values simply miss.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_hit   = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == SEL_W'(i)) begin
        sel_hit   = 1'b1;
        sel_price = PRICES[i*BAL_W +: BAL_W];
        sel_stock = stock_q[i];
      end
    end
  end

  assign coin_sum = {1'b0, balance_q} + {1'b0, coin_amount(coin_value)};
  assign coin_ok  = (coin_sum <= MAX_BAL);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= S_IDLE;
      balance_q      <= '0;
      // NOTE: the stock table is a handful of flops, not a RAM, so it is reset to its load value.
      stock_q        <= '{default: STOCK_RELOAD};
      vend_id_q      <= '0;
      dcnt_q         <= '0;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      coin_reject_q  <= 1'b0;
      err_funds_q    <= 1'b0;
      err_sold_out_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      stock_q        <= stock_d;
      vend_id_q      <= vend_id_d;
      dcnt_q         <= dcnt_d;
      vend_valid_q   <= vend_valid_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      err_funds_q    <= err_funds_d;
      err_sold_out_q <= err_sold_out_d;
`ifdef VEND_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    stock_d        = stock_q;
    vend_id_d      = vend_id_q;
    dcnt_d         = dcnt_q;
    coin_reject_d  = 1'b0;
    err_funds_d    = 1'b0;
    err_sold_out_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_d          = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (restock) stock_d = '{default: STOCK_RELOAD};
        if (coin_valid) begin
          if (coin_ok) begin
            balance_d = coin_sum[BAL_W-1:0];
            state_d   = S_COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = (balance_q != '0) ? S_CHANGE : S_IDLE;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (!sel_hit || sel_stock == '0) begin
            err_sold_out_d = 1'b1;
          end else if (balance_q < sel_price) begin
            err_funds_d = 1'b1;
          end else begin
            balance_d = balance_q - sel_price;
            for (int i = 0; i < NUM_PRODUCTS; i++)
              if (sel_id == SEL_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
            vend_id_d = sel_id;
            dcnt_d    = '0;
            state_d   = S_VEND;
          end
        end else if (coin_valid && coin_ok) begin
          balance_d = coin_sum[BAL_W-1:0];
        end else begin
          coin_reject_d = coin_valid;
`ifdef VEND_TIMEOUT_EN
          // An idle window of TIMEOUT_CYCLES behaves exactly like cancel.
          if (tmo_q == TMO_LAST) state_d = (balance_q != '0) ? S_CHANGE : S_IDLE;
          else                   tmo_d   = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_VEND: begin
        coin_reject_d = coin_valid;
        dcnt_d        = dcnt_q + DCNT_W'(1);
        if (dcnt_q == DCNT_LAST) state_d = (balance_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_valid_q && change_ready) begin
          balance_d = balance_q - coin_amount(change_coin_q);
          if (balance_d == '0) state_d = S_IDLE;
        end
      end
    endcase
    // Output registers follow the next state so they line up with state on the same edge.
    vend_valid_d   = (state_d == S_VEND);
    change_valid_d = (state_d == S_CHANGE);
    change_coin_d  = change_valid_d ? greedy_code(balance_d) : 2'd0;
  end

  always_comb begin
    state        = state_q;
    balance      = balance_q;
    vend_valid   = vend_valid_q;
    vend_id      = vend_id_q;
    change_valid = change_valid_q;
    change_coin  = change_coin_q;
    coin_reject  = coin_reject_q;
    err_funds    = err_funds_q;
    err_sold_out = err_sold_out_q;
    sold_out     = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: tb/tb_vending_core_param.sv
// Scoreboard bench for vending_core_param: directed stimulus pushes expected events,
// a negedge monitor pops and compares them against observed DUT events.
module tb_vending_core_param;

  localparam int DISP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       change_ready = 1'b1;
  logic [7:0] balance;
  logic [1:0] state;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       err_funds;
  logic       err_sold_out;
  logic [3:0] sold_out;

  vending_core_param #(.DISPENSE_CYCLES(DISP), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .restock(restock),
    .change_ready(change_ready), .balance(balance), .state(state),
    .vend_valid(vend_valid), .vend_id(vend_id), .change_valid(change_valid),
    .change_coin(change_coin), .coin_reject(coin_reject), .err_funds(err_funds),
    .err_sold_out(err_sold_out), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_REJECT = 3'd1, EV_FUNDS, EV_SOLD, EV_VEND, EV_CHANGE} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [3:0] data;
  } ev_t;

  ev_t expq[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [3:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input logic [3:0] data);
    ev_t e;
    if (expq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0d, expected none", kind, data);
    end else begin
      e = expq.pop_front();
      check("event", {25'd0, kind, data}, {25'd0, e.kind, e.data});
    end
  endtask

  // Monitor: fixed per-cycle order reject, funds, sold-out, vend start, change handshake.
  int  vlen = 0;
  logic vend_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (coin_reject)  observe(EV_REJECT, 4'd0);
        if (err_funds)    observe(EV_FUNDS, 4'd0);
        if (err_sold_out) observe(EV_SOLD, 4'd0);
        if (vend_valid && !vend_prev) observe(EV_VEND, {2'b00, vend_id});
        if (change_valid && change_ready) observe(EV_CHANGE, {2'b00, change_coin});
        if (vend_valid) vlen++;
        else if (vlen != 0) begin
          check("vend_len", vlen, DISP);
          vlen = 0;
        end
        vend_prev = vend_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_value = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [1:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == target) break;
      tick();
    end
    check(name, state, target);
  endtask

  task automatic buy25(input logic [1:0] id);
    coin(2'd3);
    coin(2'd3);
    coin(2'd2);
    expect_ev(EV_VEND, {2'b00, id});
    select(id);
    wait_state("buy_idle", 2'd0, 30);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst = 1'b0;
    tick();
    check("rst_state", state, 2'd0);
    check("rst_balance", balance, 8'd0);
    check("rst_vend_valid", vend_valid, 1'b0);
    check("rst_change_valid", change_valid, 1'b0);
    check("rst_sold_out", sold_out, 4'b0000);

    // 10 + 5 buys product 1 (price 15) exactly; coin during dispense is refused.
    coin(2'd3);
    check("t1_bal10", balance, 8'd10);
    check("t1_collect", state, 2'd1);
    coin(2'd2);
    check("t1_bal15", balance, 8'd15);
    expect_ev(EV_VEND, 4'd1);
    select(2'd1);
    check("t1_vend", state, 2'd2);
    check("t1_bal0", balance, 8'd0);
    expect_ev(EV_REJECT, 4'd0);
    coin(2'd0);
    check("t1_vend_bal", balance, 8'd0);
    wait_state("t1_idle", 2'd0, 30);

    // 25 buys product 0 (price 10): change 15 returned as 10 then 5.
    coin(2'd3);
    coin(2'd3);
    coin(2'd2);
    expect_ev(EV_VEND, 4'd0);
    expect_ev(EV_CHANGE, 4'd3);
    expect_ev(EV_CHANGE, 4'd2);
    select(2'd0);
    check("t2_bal15", balance, 8'd15);
    wait_state("t2_idle", 2'd0, 40);
    check("t2_bal0", balance, 8'd0);

    // Insufficient funds, then cancel returns a single 5.
    coin(2'd2);
    expect_ev(EV_FUNDS, 4'd0);
    select(2'd2);
    check("t3_collect", state, 2'd1);
    check("t3_bal5", balance, 8'd5);
    expect_ev(EV_CHANGE, 4'd2);
    do_cancel();
    check("t3_change", state, 2'd3);
    wait_state("t3_idle", 2'd0, 10);

    // Drain product 3, sold-out selection, restock ignored outside IDLE then honoured.
    for (int k = 0; k < 5; k++) buy25(2'd3);
    check("t4_sold_out", sold_out, 4'b1000);
    coin(2'd3);
    expect_ev(EV_SOLD, 4'd0);
    select(2'd3);
    check("t4_collect", state, 2'd1);
    check("t4_bal10", balance, 8'd10);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check("t4_restock_ignored", sold_out, 4'b1000);
    expect_ev(EV_CHANGE, 4'd3);
    do_cancel();
    wait_state("t4_idle", 2'd0, 10);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check("t4_restocked", sold_out, 4'b0000);

    // Overflow boundary: 99 accepted exactly, 100 refused; change held while not ready.
    for (int k = 0; k < 9; k++) coin(2'd3);
    coin(2'd2);
    check("t5_bal95", balance, 8'd95);
    expect_ev(EV_REJECT, 4'd0);
    coin(2'd3);
    check("t5_reject_bal", balance, 8'd95);
    coin(2'd1);
    coin(2'd1);
    check("t5_bal99", balance, 8'd99);
    expect_ev(EV_REJECT, 4'd0);
    coin(2'd0);
    check("t5_max_bal", balance, 8'd99);
    change_ready = 1'b0;
    do_cancel();
    check("t5_change", state, 2'd3);
    check("t5_coin_held0", change_coin, 2'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_coin_held", change_coin, 2'd3);
      check("t5_valid_held", change_valid, 1'b1);
      check("t5_bal_held", balance, 8'd99);
    end
    for (int k = 0; k < 9; k++) expect_ev(EV_CHANGE, 4'd3);
    expect_ev(EV_CHANGE, 4'd2);
    expect_ev(EV_CHANGE, 4'd1);
    expect_ev(EV_CHANGE, 4'd1);
    change_ready = 1'b1;
    wait_state("t5_idle", 2'd0, 40);
    check("t5_bal0", balance, 8'd0);

    // Priority: selection beats a simultaneous coin; cancel beats a simultaneous selection.
    coin(2'd3);
    expect_ev(EV_REJECT, 4'd0);
    expect_ev(EV_VEND, 4'd0);
    sel_valid  = 1'b1;
    sel_id     = 2'd0;
    coin_valid = 1'b1;
    coin_value = 2'd0;
    tick();
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    check("t6_vend", state, 2'd2);
    check("t6_bal0", balance, 8'd0);
    wait_state("t6_idle", 2'd0, 30);
    coin(2'd2);
    expect_ev(EV_CHANGE, 4'd2);
    cancel    = 1'b1;
    sel_valid = 1'b1;
    sel_id    = 2'd1;
    tick();
    cancel    = 1'b0;
    sel_valid = 1'b0;
    check("t6_cancel_wins", state, 2'd3);
    wait_state("t6_idle2", 2'd0, 10);

    coin(2'd1);
    check("t7_bal2", balance, 8'd2);
`ifdef VEND_TIMEOUT_EN
    expect_ev(EV_CHANGE, 4'd1);
    for (int k = 0; k < 15; k++) tick();
    check("t7_still_collect", state, 2'd1);
    wait_state("t7_timeout_change", 2'd3, 10);
    wait_state("t7_idle", 2'd0, 10);
`else
    for (int k = 0; k < 40; k++) tick();
    check("t7_no_timeout", state, 2'd1);
    expect_ev(EV_CHANGE, 4'd1);
    do_cancel();
    wait_state("t7_idle", 2'd0, 10);
`endif

    for (int k = 0; k < 4; k++) tick();
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_core_param.md
Name: vending_core_param

Overview:
- Parametrised next-generation vending controller: N products with per-product price and stock count, coin accumulation with overflow rejection, timed dispense, and greedy coin-by-coin change return over a valid/ready handshake.
- Sits between the coin/selection front-end (debounced, single-cycle pulses) and the dispense/change actuators and status LEDs.

Parameters:
- NUM_PRODUCTS, 4, number of selectable products (2..16); SEL_W = clog2(NUM_PRODUCTS), derived, not overridable.
- BAL_W, 8, balance and price width.
- PRICES, {8'd25,8'd20,8'd15,8'd10}, flattened price table; product i occupies bits [i*BAL_W +: BAL_W].
- MAX_BALANCE, 99, highest balance allowed.
- STOCK_W, 4, per-product stock counter width.
- INIT_STOCK, 5, stock loaded at reset and on restock.
- DISPENSE_CYCLES, 10, cycles vend_valid is held.
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-cancel (VEND_TIMEOUT_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- coin_valid  in  1  one-cycle coin pulse
- coin_value  in  2  coin code: 0=1, 1=2, 2=5, 3=10
- sel_valid  in  1  one-cycle selection pulse
- sel_id  in  SEL_W  selected product
- cancel  in  1  cancel request
- restock  in  1  reload all stock to INIT_STOCK
- change_ready  in  1  change mechanism accepts a coin
- balance  out  BAL_W  current credit
- state  out  2  0=IDLE, 1=COLLECT, 2=VEND, 3=CHANGE
- vend_valid  out  1  product being dispensed
- vend_id  out  SEL_W  product dispensed
- change_valid  out  1  change coin offered
- change_coin  out  2  coin code offered
- coin_reject  out  1  one-cycle pulse: coin refused and returned
- err_funds  out  1  one-cycle pulse: selection refused, balance < price
- err_sold_out  out  1  one-cycle pulse: selection refused, stock 0
- sold_out  out  NUM_PRODUCTS  bit i set when stock[i]==0

Behaviour:
- Reset values: state=IDLE, balance=0, vend_valid=0, vend_id=0, change_valid=0, change_coin=0, all pulses=0, every stock=INIT_STOCK, sold_out=0 unless INIT_STOCK==0.
- All outputs are registered. Events take effect on the edge after the input pulse.
- IDLE:
  - Accepted coin: balance+=value, go COLLECT.
  - restock honoured only in IDLE; ignored in all other states.
- Coin acceptance (IDLE/COLLECT):
  - Accepted when balance+value <= MAX_BALANCE.
  - Otherwise coin_reject pulses and balance is unchanged.
  - In VEND/CHANGE every coin is rejected.
- COLLECT priority: cancel > sel_valid > coin_valid. Lower-priority inputs in the same cycle are ignored, and an ignored coin pulses coin_reject.
- cancel in COLLECT: go CHANGE if balance>0, else IDLE.
- sel_valid in COLLECT:
  - sel_id >= NUM_PRODUCTS or stock==0: err_sold_out, stay in COLLECT.
  - balance < price: err_funds, stay in COLLECT.
  - Otherwise: balance-=price, stock[sel_id]-=1, vend_id<=sel_id, go VEND.
- VEND:
  - vend_valid high for exactly DISPENSE_CYCLES cycles, starting the cycle state==VEND.
  - Then go CHANGE if balance>0, else IDLE.
- CHANGE:
  - change_valid=1, change_coin=largest denomination <= balance (greedy 10,5,2,1).
  - On change_valid&&change_ready: balance-=coin.
  - When balance reaches 0: change_valid drops the same edge, go IDLE.
  - change_coin is stable while change_valid&&!change_ready.
- Arithmetic: balance is never negative and never wraps; stock saturates at 0.
- Reset mid-operation (async): dispense aborted, outstanding change discarded, stock reloaded.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined: a counter in COLLECT clears on any accepted coin or selection attempt. Reaching TIMEOUT_CYCLES acts as cancel: go CHANGE with the full balance.
- Undefined: no counter; COLLECT persists indefinitely.

Test Plan:
- Coins 10,5 then sel_id=1 -> balance 15, VEND; vend_valid 10 cycles, vend_id=1; then IDLE with balance 0; stock[1]=4.
- Coins 10,10,5 then sel_id=0 -> balance 15 after vend; CHANGE emits codes 3,2 with change_ready=1; IDLE after two handshakes.
- Balance 5, sel_id=2 -> err_funds pulse, state stays COLLECT, balance 5; then cancel -> one change coin code 2.
- Stock of product 3 drained via 5 purchases at 25 -> sold_out[3]=1; sixth selection gives err_sold_out. restock in IDLE -> sold_out[3]=0.
- Balance 95, insert 10 -> coin_reject, balance 95. Cancel with change_ready low 3 cycles -> change_coin held at 3.
- VEND_TIMEOUT_EN, TIMEOUT_CYCLES=20: insert 2, wait 20 cycles -> CHANGE, one coin code 1, then IDLE.
